// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, HI/LO, 32-step shift-add multiplier and EX/MEM register.
// Build option: define EX_FORWARDING_EN to forward from the MEM and WB stages; otherwise operands come straight from ID/EX.
module ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZEOP     = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_regA,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic [DATA_WIDTH-1:0] i_extendido,
  input  logic [SIZEOP-1:0]     i_opcode,
  input  logic [4:0]            i_rs,
  input  logic [4:0]            i_rt,
  input  logic [4:0]            i_rd,
  input  logic [3:0]            i_ex,
  input  logic [2:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic [1:0]            i_sizemem,
  input  logic                  i_signedmem,
  input  logic [DATA_WIDTH-1:0] i_return_address,
  input  logic                  i_return,
  input  logic                  i_halt,
  input  logic [DATA_WIDTH-1:0] i_mem_fwd_data,
  input  logic [4:0]            i_mem_fwd_reg,
  input  logic                  i_mem_fwd_we,
  input  logic [DATA_WIDTH-1:0] i_wb_fwd_data,
  input  logic [4:0]            i_wb_fwd_reg,
  input  logic                  i_wb_fwd_we,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic [4:0]            o_write_reg,
  output logic [2:0]            o_mem,
  output logic [1:0]            o_wb,
  output logic [1:0]            o_sizemem,
  output logic                  o_signedmem,
  output logic [DATA_WIDTH-1:0] o_return_address,
  output logic                  o_return,
  output logic                  o_halt,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [SIZEOP-1:0] OP_ADDI = 'h08, OP_ADDIU = 'h09, OP_SLTI = 'h0A, OP_SLTIU = 'h0B;
  localparam logic [SIZEOP-1:0] OP_ANDI = 'h0C, OP_ORI   = 'h0D, OP_XORI = 'h0E, OP_LUI   = 'h0F;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t state_q, state_d;

  logic                  adv;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] opa, opb, op2, alu_res, imm_zext;
  logic signed [DATA_WIDTH-1:0] opa_s, op2_s;
  logic                  is_mult, signed_mult, bubble;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]         acc_q, mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q, hi_q, lo_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q;

  logic [DATA_WIDTH-1:0] alu_result_p1, write_data_p1, return_address_p1;
  logic [4:0]            write_reg_p1;
  logic [2:0]            mem_p1;
  logic [1:0]            wb_p1, sizemem_p1;
  logic                  signedmem_p1, return_p1, halt_p1;

  assign adv   = i_start && i_step;
  assign funct = i_extendido[5:0];
  assign shamt = i_extendido[10:6];

`ifdef EX_FORWARDING_EN
  // MEM result is newer than WB, so it wins when both target the same register.
  function automatic logic [DATA_WIDTH-1:0] fwd_pick(input logic [4:0] idx,
                                                     input logic [DATA_WIDTH-1:0] id_val);
    logic [DATA_WIDTH-1:0] res;
    res = id_val;
    if (i_mem_fwd_we && (i_mem_fwd_reg == idx) && (idx != 5'd0))
      res = i_mem_fwd_data;
    else if (i_wb_fwd_we && (i_wb_fwd_reg == idx) && (idx != 5'd0))
      res = i_wb_fwd_data;
    return res;
  endfunction

  assign opa = fwd_pick(i_rs, i_regA);
  assign opb = fwd_pick(i_rt, i_regB);
`else
  logic unused_fwd;
  assign opa = i_regA;
  assign opb = i_regB;
  assign unused_fwd = ^{i_rs, i_mem_fwd_data, i_mem_fwd_reg, i_mem_fwd_we,
                        i_wb_fwd_data, i_wb_fwd_reg, i_wb_fwd_we};
`endif

  assign op2      = i_ex[2] ? i_extendido : opb;
  assign opa_s    = opa;
  assign op2_s    = op2;
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, i_extendido[15:0]};

  always_comb begin
    alu_res = '0;
    unique case (i_ex[1:0])
      2'b00: alu_res = opa + op2;
      2'b01: alu_res = opa - op2;
      2'b10: begin
        case (funct)
          F_SLL:          alu_res = op2 << shamt;
          F_SRL:          alu_res = op2 >> shamt;
          F_SRA:          alu_res = op2_s >>> shamt;
          F_SLLV:         alu_res = op2 << opa[4:0];
          F_SRLV:         alu_res = op2 >> opa[4:0];
          F_SRAV:         alu_res = op2_s >>> opa[4:0];
          F_MFHI:         alu_res = hi_q;
          F_MFLO:         alu_res = lo_q;
          F_ADD, F_ADDU:  alu_res = opa + op2;
          F_SUB, F_SUBU:  alu_res = opa - op2;
          F_AND:          alu_res = opa & op2;
          F_OR:           alu_res = opa | op2;
          F_XOR:          alu_res = opa ^ op2;
          F_NOR:          alu_res = ~(opa | op2);
          F_SLT:          alu_res = {{(DATA_WIDTH-1){1'b0}}, (opa_s < op2_s)};
          F_SLTU:         alu_res = {{(DATA_WIDTH-1){1'b0}}, (opa < op2)};
          default:        alu_res = '0;
        endcase
      end
      default: begin
        case (i_opcode)
          OP_ADDI, OP_ADDIU: alu_res = opa + op2;
          OP_SLTI:           alu_res = {{(DATA_WIDTH-1){1'b0}}, (opa_s < op2_s)};
          OP_SLTIU:          alu_res = {{(DATA_WIDTH-1){1'b0}}, (opa < op2)};
          OP_ANDI:           alu_res = opa & imm_zext;
          OP_ORI:            alu_res = opa | imm_zext;
          OP_XORI:           alu_res = opa ^ imm_zext;
          OP_LUI:            alu_res = {i_extendido[15:0], {(DATA_WIDTH-16){1'b0}}};
          default:           alu_res = '0;
        endcase
      end
    endcase
  end

  assign is_mult     = (i_ex[1:0] == 2'b10) && ((funct == F_MULT) || (funct == F_MULTU));
  assign signed_mult = (funct == F_MULT);
  assign mag_a       = (signed_mult && opa[DATA_WIDTH-1]) ? -opa : opa;
  assign mag_b       = (signed_mult && opb[DATA_WIDTH-1]) ? -opb : opb;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else if (adv) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (is_mult) state_d = BUSY;
      BUSY:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplier: magnitudes are multiplied unsigned, sign applied once at the end.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (adv) begin
      case (state_q)
        IDLE: if (is_mult) begin
          acc_q    <= '0;
          mcand_q  <= {{DATA_WIDTH{1'b0}}, mag_a};
          mplier_q <= mag_b;
          cnt_q    <= '0;
          neg_q    <= signed_mult && (opa[DATA_WIDTH-1] ^ opb[DATA_WIDTH-1]);
        end
        BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        DONE: {hi_q, lo_q} <= neg_q ? -acc_q : acc_q;
        default: ;
      endcase
    end
  end

  assign o_stall = (state_q != IDLE);
  assign bubble  = o_stall || is_mult;

  // EX/MEM boundary
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      alu_result_p1     <= '0;
      write_data_p1     <= '0;
      write_reg_p1      <= '0;
      mem_p1            <= '0;
      wb_p1             <= '0;
      sizemem_p1        <= '0;
      signedmem_p1      <= 1'b0;
      return_address_p1 <= '0;
      return_p1         <= 1'b0;
      halt_p1           <= 1'b0;
    end else if (adv) begin
      alu_result_p1     <= alu_res;
      write_data_p1     <= opb;
      write_reg_p1      <= i_ex[3] ? i_rd : i_rt;
      mem_p1            <= bubble ? 3'b000 : i_mem;
      wb_p1             <= bubble ? 2'b00 : i_wb;
      sizemem_p1        <= i_sizemem;
      signedmem_p1      <= i_signedmem;
      return_address_p1 <= i_return_address;
      return_p1         <= bubble ? 1'b0 : i_return;
      halt_p1           <= bubble ? 1'b0 : i_halt;
    end
  end

  assign o_alu_result     = alu_result_p1;
  assign o_write_data     = write_data_p1;
  assign o_write_reg      = write_reg_p1;
  assign o_mem            = mem_p1;
  assign o_wb             = wb_p1;
  assign o_sizemem        = sizemem_p1;
  assign o_signedmem      = signedmem_p1;
  assign o_return_address = return_address_p1;
  assign o_return         = return_p1;
  assign o_halt           = halt_p1;
  assign o_hi             = hi_q;
  assign o_lo             = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed ALU, forwarding, multiplier, step-gating and reset vectors.
module tb_ex_stage;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_step;
  logic [31:0] i_regA, i_regB, i_extendido, i_return_address;
  logic [5:0]  i_opcode;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [3:0]  i_ex;
  logic [2:0]  i_mem;
  logic [1:0]  i_wb, i_sizemem;
  logic        i_signedmem, i_return, i_halt;
  logic [31:0] i_mem_fwd_data, i_wb_fwd_data;
  logic [4:0]  i_mem_fwd_reg, i_wb_fwd_reg;
  logic        i_mem_fwd_we, i_wb_fwd_we;
  logic [31:0] o_alu_result, o_write_data, o_return_address, o_hi, o_lo;
  logic [4:0]  o_write_reg;
  logic [2:0]  o_mem;
  logic [1:0]  o_wb, o_sizemem;
  logic        o_signedmem, o_return, o_halt, o_stall;

  ex_stage #(.DATA_WIDTH(32), .SIZEOP(6)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_step(i_step),
    .i_regA(i_regA), .i_regB(i_regB), .i_extendido(i_extendido), .i_opcode(i_opcode),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ex(i_ex), .i_mem(i_mem), .i_wb(i_wb),
    .i_sizemem(i_sizemem), .i_signedmem(i_signedmem), .i_return_address(i_return_address),
    .i_return(i_return), .i_halt(i_halt),
    .i_mem_fwd_data(i_mem_fwd_data), .i_mem_fwd_reg(i_mem_fwd_reg), .i_mem_fwd_we(i_mem_fwd_we),
    .i_wb_fwd_data(i_wb_fwd_data), .i_wb_fwd_reg(i_wb_fwd_reg), .i_wb_fwd_we(i_wb_fwd_we),
    .o_alu_result(o_alu_result), .o_write_data(o_write_data), .o_write_reg(o_write_reg),
    .o_mem(o_mem), .o_wb(o_wb), .o_sizemem(o_sizemem), .o_signedmem(o_signedmem),
    .o_return_address(o_return_address), .o_return(o_return), .o_halt(o_halt),
    .o_stall(o_stall), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic [2:0]  mem;
    logic        halt;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  adv_seen = 1'b0;
  exp_t  e;
  string en;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  always @(posedge clk) adv_seen <= i_start && i_step && i_reset;

  // Monitor: every non-bubble EX/MEM capture must match the oldest expectation.
  always @(negedge clk) begin
    if (adv_seen && o_wb[1]) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got 0x%0h expected none", o_alu_result);
      end else begin
        e  = exp_q.pop_front();
        en = nm_q.pop_front();
        check({en, "_alu"},  o_alu_result, e.alu);
        check({en, "_reg"},  o_write_reg,  e.wreg);
        check({en, "_wd"},   o_write_data, e.wd);
        check({en, "_mem"},  o_mem,        e.mem);
        check({en, "_halt"}, o_halt,       e.halt);
      end
    end
  end

  task automatic setin(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
                       input logic [5:0] opc, input logic [3:0] ex,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    i_regA = a; i_regB = b; i_extendido = ext; i_opcode = opc; i_ex = ex;
    i_rs = rs; i_rt = rt; i_rd = rd;
  endtask

  task automatic push_exp(input string nm, input logic [31:0] a, input logic [4:0] r,
                          input logic [31:0] wd);
    exp_t t;
    t.alu = a; t.wreg = r; t.wd = wd; t.mem = i_mem; t.halt = i_halt;
    exp_q.push_back(t);
    nm_q.push_back(nm);
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input logic [4:0] r,
                       input logic [31:0] wd);
    push_exp(nm, a, r, wd);
    i_start = 1'b1;
    i_step  = 1'b1;
    @(negedge clk);
    i_step  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   m;
    logic bub_bad;
    logic frozen_bad;
    logic [31:0] snap_alu, snap_lo;

    i_reset = 1'b0; i_start = 1'b0; i_step = 1'b0;
    setin(0, 0, 0, 0, 4'b0000, 0, 0, 0);
    i_mem = 3'b001; i_wb = 2'b10; i_sizemem = 2'b10; i_signedmem = 1'b0;
    i_return_address = 32'h40; i_return = 1'b0; i_halt = 1'b0;
    i_mem_fwd_data = 0; i_mem_fwd_reg = 0; i_mem_fwd_we = 0;
    i_wb_fwd_data = 0;  i_wb_fwd_reg = 0;  i_wb_fwd_we = 0;
    repeat (2) @(negedge clk);

    check("rst_alu",   o_alu_result, 0);
    check("rst_reg",   o_write_reg,  0);
    check("rst_wb",    o_wb,         0);
    check("rst_stall", o_stall,      0);
    check("rst_hi",    o_hi,         0);
    check("rst_lo",    o_lo,         0);
    i_reset = 1'b1;
    @(negedge clk);

    setin(5, 7, 32'h20, 0, 4'b1010, 1, 2, 3);
    issue("add", 32'd12, 5'd3, 32'd7);

    // Asynchronous reset between clock edges
    #2 i_reset = 1'b0;
    #1;
    check("async_rst_alu", o_alu_result, 0);
    check("async_rst_reg", o_write_reg,  0);
    check("async_rst_wd",  o_write_data, 0);
    check("async_rst_wb",  o_wb,         0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);

    i_mem_fwd_data = 32'h11; i_mem_fwd_reg = 5'd4; i_mem_fwd_we = 1'b1;
    i_wb_fwd_data  = 32'h22; i_wb_fwd_reg  = 5'd4; i_wb_fwd_we  = 1'b1;
    i_mem = 3'b101; i_halt = 1'b1;
    setin(32'h100, 1, 32'h20, 0, 4'b1010, 4, 5, 6);
    issue("fwd_mem_prio", FWD ? 32'h12 : 32'h101, 5'd6, 32'd1);
    i_mem = 3'b001; i_halt = 1'b0;
    i_mem_fwd_we = 1'b0;
    issue("fwd_wb_only", FWD ? 32'h23 : 32'h101, 5'd6, 32'd1);
    i_mem_fwd_we = 1'b1; i_mem_fwd_reg = 5'd0; i_wb_fwd_reg = 5'd0;
    setin(32'h100, 1, 32'h20, 0, 4'b1010, 0, 5, 6);
    issue("fwd_rs_zero", 32'h101, 5'd6, 32'd1);
    i_mem_fwd_we = 1'b0; i_wb_fwd_we = 1'b0;

    setin(0, 0, 32'h1234, 6'h0F, 4'b0111, 1, 9, 3);
    issue("lui", 32'h12340000, 5'd9, 32'd0);
    setin(32'h80000000, 32'h80000000, 32'h103, 0, 4'b1010, 1, 2, 10);
    issue("sra", 32'hF8000000, 5'd10, 32'h80000000);
    setin(1, 0, 32'hFFFFFFFF, 6'h0B, 4'b0111, 1, 11, 0);
    issue("sltiu", 32'd1, 5'd11, 32'd0);
    setin(1, 0, 32'hFFFFFFFF, 6'h0A, 4'b0111, 1, 12, 0);
    issue("slti", 32'd0, 5'd12, 32'd0);
    setin(3, 5, 0, 0, 4'b1001, 1, 2, 13);
    issue("sub_wrap", 32'hFFFFFFFE, 5'd13, 32'd5);
    setin(0, 32'hF0F0F0F0, 32'h27, 0, 4'b1010, 1, 2, 14);
    issue("nor", 32'h0F0F0F0F, 5'd14, 32'hF0F0F0F0);
    setin(4, 1, 32'h04, 0, 4'b1010, 1, 2, 15);
    issue("sllv", 32'h10, 5'd15, 32'd1);
    setin(32'hFFFFFFFF, 1, 32'h2A, 0, 4'b1010, 1, 2, 16);
    issue("slt", 32'd1, 5'd16, 32'd1);
    setin(32'hFFFFFFFF, 1, 32'h2B, 0, 4'b1010, 1, 2, 17);
    issue("sltu", 32'd0, 5'd17, 32'd1);

    // Signed MULT followed by a dependent MFLO held upstream during the stall
    setin(32'hFFFFFFFD, 7, 32'h18, 0, 4'b1010, 1, 2, 0);
    i_start = 1'b1; i_step = 1'b1;
    @(negedge clk);
    setin(0, 0, 32'h12, 0, 4'b1010, 0, 0, 8);
    push_exp("mflo", 32'hFFFFFFEB, 5'd8, 32'd0);
    n = 0; bub_bad = 1'b0;
    while (o_stall && n < 100) begin
      if (o_wb != 0 || o_mem != 0 || o_halt || o_return) bub_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("mult_stall_cycles", n, 33);
    check("mult_bubbles", bub_bad, 0);
    check("mult_hi", o_hi, 32'hFFFFFFFF);
    check("mult_lo", o_lo, 32'hFFFFFFEB);
    @(negedge clk);
    i_step = 1'b0;

    // MULTU with a 10-cycle step freeze partway through
    setin(32'hFFFFFFFF, 2, 32'h19, 0, 4'b1010, 1, 2, 0);
    i_step = 1'b1;
    @(negedge clk);
    setin(0, 0, 32'h10, 0, 4'b1010, 0, 0, 9);
    push_exp("mfhi", 32'd1, 5'd9, 32'd0);
    repeat (10) @(negedge clk);
    i_step = 1'b0;
    snap_alu = o_alu_result; snap_lo = o_lo;
    frozen_bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!o_stall || o_alu_result != snap_alu || o_lo != snap_lo || o_wb != 0) frozen_bad = 1'b1;
    end
    check("step_gate_frozen", frozen_bad, 0);
    i_step = 1'b1;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (o_stall && m < 100);
    check("multu_remaining", m, 23);
    check("multu_hi", o_hi, 32'd1);
    check("multu_lo", o_lo, 32'hFFFFFFFE);
    @(negedge clk);
    i_step = 1'b0;

    // Reset while the multiplier is busy
    setin(5, 5, 32'h18, 0, 4'b1010, 1, 2, 0);
    i_step = 1'b1;
    repeat (6) @(negedge clk);
    i_step = 1'b0;
    check("mid_mult_stall", o_stall, 1);
    #2 i_reset = 1'b0;
    #1;
    check("abort_stall", o_stall, 0);
    check("abort_hi", o_hi, 0);
    check("abort_lo", o_lo, 0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    setin(1, 1, 32'h21, 0, 4'b1010, 1, 2, 20);
    issue("post_abort_add", 32'd2, 5'd20, 32'd1);
    check("post_abort_stall", o_stall, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
